sdf_stage_32: RTL and testbench
===============================

SDF_STAGE_32 -- requirements
Module: sdf_stage_32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports declared as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  din_r/din_i carry a sample this cycle.
REQ-005 din_r, din_i  input  24 each  signed complex input sample, Q16.8 two's complement.
REQ-006 state  input  2  phase from the twiddle ROM: 0 = fill, 1 = butterfly, 2 = twiddle; 3 is treated as 0.
REQ-007 w_r, w_i  input  24 each  signed twiddle from the twiddle ROM, Q16.8 (256 = 1.0), valid in the same cycle as state.
REQ-008 out_valid  output  1  dout_r/dout_i carry a result sample.
REQ-009 dout_r, dout_i  output  24 each  signed complex result, Q16.8.

Function
REQ-010 The block SHALL contain a 32-entry complex delay line (FIFO order, 48 bits per entry); head = oldest entry.
REQ-011 Shift enable SHALL be (state==0 and in_valid) or state==1 or state==2; otherwise the delay line holds.
REQ-012 State 0, in_valid=1: push din; out_valid SHALL be 0 next cycle.
REQ-013 State 1 (every cycle): a = head, b = din; register a+b to dout; push a-b; out_valid=1 next cycle.
REQ-014 State 2 (every cycle): register head*w to dout; push din if in_valid, else push 0; out_valid=1 next cycle.
REQ-015 Complex multiply: re = (ar*wr - ai*wi), im = (ar*wi + ai*wr), computed at full 49-bit signed precision, arithmetic-shifted right by 8, low 24 bits kept.
REQ-016 Add/subtract SHALL be 24-bit two's complement, wrapping modulo 2^24; no saturation.
REQ-017 Latency SHALL be exactly 1 clock from an input cycle to its dout/out_valid; all outputs SHALL be registered.
REQ-018 In state 0 with in_valid=0, and in state 3, dout SHALL hold its last value and out_valid SHALL be 0.
REQ-019 Transition 1->2 or 2->1 SHALL take effect on the first cycle of the new state with no bubble; the delay line contents SHALL carry across.
REQ-020 Phase sequencing SHALL be owned entirely by the state input; the block SHALL keep no frame counter of its own.

Reset
REQ-021 When rst_n is low, out_valid, dout_r, dout_i and all 32 delay entries SHALL clear to 0 asynchronously.
REQ-022 A reset asserted mid-frame SHALL discard all buffered samples; the first post-reset result SHALL be computed from zero entries.

Configuration
REQ-023 With SDF_STAGE_ROUND_EN defined, the multiplier SHALL add 128 before the >>8 shift (round half up).
REQ-024 Without SDF_STAGE_ROUND_EN, the multiplier SHALL truncate (floor) at the >>8 shift; all other behaviour SHALL be identical.

Verification
REQ-025 Reset, then state=0, in_valid=1, din=(k,0) for k=0..31 -> out_valid stays 0 for all 32 cycles.
REQ-026 Then state=1 for 32 cycles, din=(100,0) -> dout=(k+100,0) for k=0..31, one cycle after each input, out_valid=1.
REQ-027 Then state=2 for 32 cycles, w=(256,0) -> dout=(k-100,0) for k=0..31.
REQ-028 Buffered head=(-100,0), w_r=0, w_i=0xFFFF00 (-1.0) in state 2 -> dout=(0,100).
REQ-029 Head=(1,0), w=(128,0) in state 2 -> dout_r=1 with SDF_STAGE_ROUND_EN defined; dout_r=0 without it.
REQ-030 Assert rst_n=0 during cycle 10 of state 1 -> outputs go to 0 immediately; after release, state=1 with din=(5,0) -> dout=(5,0).

Source files
------------

// File: rtl/sdf_stage_32.sv
// sdf_stage_32 -- one radix-2 single-path delay-feedback FFT stage.
// A 32-deep complex delay line feeds a butterfly (state 1) or a complex
// twiddle multiply (state 2). The phase comes from the external twiddle ROM
// through the state input; the block keeps no frame counter of its own.
// Build option: define SDF_STAGE_ROUND_EN to round half up at the
// multiplier's >>8 instead of truncating.
module sdf_stage_32 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [23:0] din_r,
  input  logic signed [23:0] din_i,
  input  logic        [1:0]  state,
  input  logic signed [23:0] w_r,
  input  logic signed [23:0] w_i,
  output logic               out_valid,
  output logic signed [23:0] dout_r,
  output logic signed [23:0] dout_i
);

  typedef enum logic [1:0] {
    PH_FILL = 2'd0,
    PH_BFLY = 2'd1,
    PH_TWID = 2'd2,
    PH_RSVD = 2'd3
  } phase_e;

  localparam int unsigned DEPTH = 32;

  // Entry layout: {re[47:24], im[23:0]}; line_q[0] is the head (oldest).
  logic [47:0]        line_q [DEPTH];
  logic [47:0]        push_d;
  logic               shift_en;

  logic signed [23:0] head_r, head_i;
  logic signed [47:0] p_rr, p_ii, p_ri, p_ir;
  logic        [48:0] re_full, im_full;
  logic        [23:0] mul_r, mul_i;

  logic               out_valid_d, out_valid_q;
  logic        [23:0] dout_r_d, dout_r_q;
  logic        [23:0] dout_i_d, dout_i_q;

  phase_e             phase;

  // Head split and full-precision complex multiply of head by twiddle.
  always_comb begin
    head_r  = line_q[0][47:24];
    head_i  = line_q[0][23:0];
    p_rr    = head_r * w_r;
    p_ii    = head_i * w_i;
    p_ri    = head_r * w_i;
    p_ir    = head_i * w_r;
    re_full = {p_rr[47], p_rr} - {p_ii[47], p_ii};
    im_full = {p_ri[47], p_ri} + {p_ir[47], p_ir};
`ifdef SDF_STAGE_ROUND_EN
    re_full = re_full + 49'd128;
    im_full = im_full + 49'd128;
`endif
    // Arithmetic >>8 then keep 24 bits is just bits [31:8] of the sum.
    mul_r   = re_full[31:8];
    mul_i   = im_full[31:8];
  end

  // Phase decode: shift enable, value pushed into the line, next outputs.
  always_comb begin
    phase       = phase_e'(state);
    shift_en    = 1'b0;
    push_d      = '0;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    case (phase)
      PH_BFLY: begin
        shift_en    = 1'b1;
        out_valid_d = 1'b1;
        dout_r_d    = head_r + din_r;
        dout_i_d    = head_i + din_i;
        push_d      = {24'(head_r - din_r), 24'(head_i - din_i)};
      end
      PH_TWID: begin
        shift_en    = 1'b1;
        out_valid_d = 1'b1;
        dout_r_d    = mul_r;
        dout_i_d    = mul_i;
        push_d      = in_valid ? {din_r, din_i} : '0;
      end
      default: begin
        // Fill, and the reserved code 3 which behaves as fill.
        shift_en = in_valid;
        push_d   = {din_r, din_i};
      end
    endcase
  end

  // Delay line: shift toward the head, new sample enters at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) line_q[i] <= line_q[i + 1];
      line_q[DEPTH - 1] <= push_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_sdf_stage_32.sv
// Self-checking bench for sdf_stage_32 using a FIFO model and a
// scoreboard of expected per-cycle outputs.
module tb_sdf_stage_32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic        [1:0]  state = 2'd0;
  logic signed [23:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic               out_valid;
  logic signed [23:0] dout_r, dout_i;

  always #5 clk = ~clk;

  sdf_stage_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .din_r    (din_r),
    .din_i    (din_i),
    .state    (state),
    .w_r      (w_r),
    .w_i      (w_i),
    .out_valid(out_valid),
    .dout_r   (dout_r),
    .dout_i   (dout_i)
  );

  typedef struct {
    logic signed [23:0] r;
    logic signed [23:0] i;
  } cplx_t;

  typedef struct {
    logic        v;
    logic [23:0] r;
    logic [23:0] i;
  } exp_t;

  cplx_t       line[$];
  exp_t        sb[$];
  logic [23:0] hold_r, hold_i;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [23:0] scale(input longint p);
    longint q;
    q = p;
`ifdef SDF_STAGE_ROUND_EN
    q = q + 128;
`endif
    q = q >>> 8;
    return q[23:0];
  endfunction

  function automatic void model_reset();
    cplx_t z;
    z.r = '0;
    z.i = '0;
    line.delete();
    for (int i = 0; i < 32; i++) line.push_back(z);
    sb.delete();
    hold_r = '0;
    hold_i = '0;
  endfunction

  // Drive one input cycle and push the output the model expects for it.
  task automatic apply(input logic [1:0] st, input logic v,
                       input int dr, input int di, input int wr, input int wi);
    cplx_t h, pu;
    exp_t  e;
    state    = st;
    in_valid = v;
    din_r    = dr[23:0];
    din_i    = di[23:0];
    w_r      = wr[23:0];
    w_i      = wi[23:0];
    h   = line[0];
    e.v = 1'b0;
    e.r = hold_r;
    e.i = hold_i;
    case (st)
      2'd1: begin
        e.v  = 1'b1;
        e.r  = h.r + din_r;
        e.i  = h.i + din_i;
        pu.r = h.r - din_r;
        pu.i = h.i - din_i;
        void'(line.pop_front());
        line.push_back(pu);
      end
      2'd2: begin
        e.v  = 1'b1;
        e.r  = scale(longint'(h.r) * longint'(w_r) - longint'(h.i) * longint'(w_i));
        e.i  = scale(longint'(h.r) * longint'(w_i) + longint'(h.i) * longint'(w_r));
        pu.r = v ? din_r : 24'sd0;
        pu.i = v ? din_i : 24'sd0;
        void'(line.pop_front());
        line.push_back(pu);
      end
      default: begin
        if (v) begin
          pu.r = din_r;
          pu.i = din_i;
          void'(line.pop_front());
          line.push_back(pu);
        end
      end
    endcase
    hold_r = e.r;
    hold_i = e.i;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || dout_r !== 24'sd0 || dout_i !== 24'sd0) begin
      miscompares++;
      $display("FAIL reset: got v=%b (%0d,%0d) want v=0 (0,0)", out_valid, dout_r, dout_i);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      apply(2'd0, 1'b1, k, 0, 0, 0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (out_valid !== e.v || dout_r !== e.r || dout_i !== e.i) begin
        miscompares++;
        $display("FAIL fill k=%0d: got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, $signed(e.r), $signed(e.i));
      end
    end
  endtask

  task automatic test_butterfly();
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      apply(2'd1, 1'b1, 100, 0, 0, 0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (out_valid !== e.v || dout_r !== e.r || dout_i !== e.i) begin
        miscompares++;
        $display("FAIL butterfly k=%0d: got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, $signed(e.r), $signed(e.i));
      end
    end
  endtask

  // Unit twiddle; also loads (-100,0) then (1,0) at the head for the next test.
  task automatic test_twiddle();
    exp_t e;
    int   d;
    for (int k = 0; k < 32; k++) begin
      d = (k == 0) ? -100 : (k == 1) ? 1 : 3 * k - 40;
      apply(2'd2, 1'b1, d, k, 256, 0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (out_valid !== e.v || dout_r !== e.r || dout_i !== e.i) begin
        miscompares++;
        $display("FAIL twiddle k=%0d: got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, $signed(e.r), $signed(e.i));
      end
    end
  endtask

  // Twiddle -1.0j on (-100,0), then 0.5 on (1,0) which exposes the rounding mode.
  task automatic test_twiddle_edge();
    exp_t e;
    apply(2'd2, 1'b0, 0, 0, 0, -256);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || dout_r !== 24'sd0 || dout_i !== 24'sd100 ||
        dout_r !== e.r || dout_i !== e.i) begin
      miscompares++;
      $display("FAIL twiddle_neg_j: got v=%b (%0d,%0d) want v=1 (0,100)",
               out_valid, dout_r, dout_i);
    end
    apply(2'd2, 1'b0, 0, 0, 128, 0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || dout_r !== e.r || dout_i !== e.i) begin
      miscompares++;
      $display("FAIL twiddle_half: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
               out_valid, dout_r, dout_i, $signed(e.r), $signed(e.i));
    end
  endtask

  // Idle fill and reserved phase hold dout with out_valid low.
  task automatic test_hold();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      apply((k < 3) ? 2'd0 : 2'd3, 1'b0, 77, 77, 9, 9);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (out_valid !== e.v || dout_r !== e.r || dout_i !== e.i) begin
        miscompares++;
        $display("FAIL hold k=%0d: got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, $signed(e.r), $signed(e.i));
      end
    end
  endtask

  // Random phases, gaps and data, including back-to-back 1<->2 transitions.
  task automatic test_random();
    exp_t e;
    for (int k = 0; k < 300; k++) begin
      apply(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (out_valid !== e.v || dout_r !== e.r || dout_i !== e.i) begin
        miscompares++;
        $display("FAIL random k=%0d st=%0d: got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                 k, state, out_valid, dout_r, dout_i, e.v, $signed(e.r), $signed(e.i));
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    for (int k = 0; k < 9; k++) begin
      apply(2'd1, 1'b1, 1000 + k, -k, 0, 0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (out_valid !== e.v || dout_r !== e.r || dout_i !== e.i) begin
        miscompares++;
        $display("FAIL midframe_pre k=%0d: got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                 k, out_valid, dout_r, dout_i, e.v, $signed(e.r), $signed(e.i));
      end
    end
    state    = 2'd1;
    in_valid = 1'b1;
    din_r    = 24'sd7;
    din_i    = 24'sd7;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || dout_r !== 24'sd0 || dout_i !== 24'sd0) begin
      miscompares++;
      $display("FAIL midframe_async: got v=%b (%0d,%0d) want v=0 (0,0)",
               out_valid, dout_r, dout_i);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(2'd1, 1'b1, 5, 0, 0, 0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || dout_r !== 24'sd5 || dout_i !== 24'sd0 ||
        dout_r !== e.r || dout_i !== e.i) begin
      miscompares++;
      $display("FAIL midframe_post: got v=%b (%0d,%0d) want v=1 (5,0)",
               out_valid, dout_r, dout_i);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_butterfly();
    test_twiddle();
    test_twiddle_edge();
    test_hold();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
